// File: rtl/lane_scheduler.sv
// lane_scheduler: shared movement tick, one-hot lane step sweep, and the level-start reseed/audit loop.
// Sits between the game FSM and the lane mover array; all outputs are registered.
module lane_scheduler #(
  parameter int NUM_LANES     = 8,
  parameter int TICK_DIV      = 2000000,
  parameter int SEED_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int FAST_THRESH   = 6,
  parameter int MAX_RETRY     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   level_start,
  input  logic                   freeze,
  input  logic [9*NUM_LANES-1:0] lane_speed,
  output logic [NUM_LANES-1:0]   step_en,
  output logic                   frame_tick,
  output logic                   reseed_n,
  output logic                   level_ok,
  output logic [1:0]             retries,
  output logic                   busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEED   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_AUDIT  = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int PH_MAX = (SEED_CYCLES > SETTLE_CYCLES) ? SEED_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int LANE_W = $clog2(NUM_LANES);

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]   SEED_LAST   = PH_W'(SEED_CYCLES - 1);
  localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [LANE_W-1:0] LANE_LAST   = LANE_W'(NUM_LANES - 2);
  localparam logic [8:0]        FAST_MAG    = 9'(FAST_THRESH);
  localparam logic [1:0]        RETRY_MAX   = 2'(MAX_RETRY);

  logic [2:0]        state;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  div_next;
  logic [PH_W-1:0]   phase;
  logic [LANE_W-1:0] lane_idx;
  logic              fail_acc;
  logic [8:0]        spd [NUM_LANES];
  logic [8:0]        spd_a;
  logic [8:0]        spd_b;
  logic              pair_bad;
  logic              audit_fail_now;

  // Negating -256 in 9 bits yields 9'h100, which compares as 256 and so counts as fast.
  function automatic logic is_fast(input logic [8:0] s);
    logic [8:0] mag;
    mag = s[8] ? (~s + 9'd1) : s;
    return mag >= FAST_MAG;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      spd[i] = lane_speed[9*i +: 9];
    end
  end

  assign spd_a          = spd[lane_idx];
  assign spd_b          = spd[lane_idx + LANE_W'(1)];
  assign pair_bad       = (is_fast(spd_a) && is_fast(spd_b) && (spd_a[8] == spd_b[8]))
                          || (spd_a == 9'd0) || (spd_b == 9'd0);
  assign audit_fail_now = fail_acc | pair_bad;
  assign div_next       = (div == DIV_LAST) ? '0 : div + DIV_W'(1);

  // frame_tick is loaded from the divider's next value so it lines up with div == TICK_DIV-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      div        <= '0;
      phase      <= '0;
      lane_idx   <= '0;
      fail_acc   <= 1'b0;
      step_en    <= '0;
      frame_tick <= 1'b0;
      reseed_n   <= 1'b1;
      level_ok   <= 1'b0;
      retries    <= 2'd0;
      busy       <= 1'b0;
    end else if (!enable) begin
      state      <= S_IDLE;
      div        <= '0;
      phase      <= '0;
      lane_idx   <= '0;
      fail_acc   <= 1'b0;
      step_en    <= '0;
      frame_tick <= 1'b0;
      reseed_n   <= 1'b1;
      level_ok   <= 1'b0;
      retries    <= 2'd0;
      busy       <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        div        <= '0;
        frame_tick <= 1'b0;
      end else begin
        div        <= div_next;
        frame_tick <= (div_next == DIV_LAST);
      end

      if (level_start) begin
        state    <= S_SEED;
        phase    <= '0;
        fail_acc <= 1'b0;
        step_en  <= '0;
        reseed_n <= 1'b0;
        level_ok <= 1'b0;
        retries  <= 2'd0;
        busy     <= 1'b1;
      end else begin
        case (state)
          S_SEED: begin
            if (phase == SEED_LAST) begin
              state    <= S_SETTLE;
              phase    <= '0;
              reseed_n <= 1'b1;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
          S_SETTLE: begin
            if (phase == SETTLE_LAST) begin
              state    <= S_AUDIT;
              lane_idx <= '0;
              fail_acc <= 1'b0;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
          // One adjacent pair per cycle; the verdict is taken on the last pair.
          S_AUDIT: begin
            if (lane_idx == LANE_LAST) begin
              if (!audit_fail_now) begin
                state    <= S_RUN;
                level_ok <= 1'b1;
                busy     <= 1'b0;
              end else if (retries == RETRY_MAX) begin
                state    <= S_RUN;
                level_ok <= 1'b0;
                busy     <= 1'b0;
              end else begin
                state    <= S_SEED;
                phase    <= '0;
                retries  <= retries + 2'd1;
                reseed_n <= 1'b0;
              end
            end else begin
              lane_idx <= lane_idx + LANE_W'(1);
              fail_acc <= audit_fail_now;
            end
          end
          S_RUN: begin
            if (step_en != '0) begin
              step_en <= step_en << 1;
            end else if (frame_tick && !freeze) begin
              step_en <= NUM_LANES'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lane_scheduler.sv
// Bench for lane_scheduler: directed scenarios plus random traffic, compared each cycle
// against a timeline model built from elapsed-cycle arithmetic.
module tb_lane_scheduler;

  localparam int NL  = 4;
  localparam int TD  = 16;
  localparam int SC  = 2;
  localparam int STC = 4;
  localparam int FT  = 6;
  localparam int MR  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          level_start;
  logic          freeze;
  logic [9*NL-1:0] lane_speed;
  logic [NL-1:0] step_en;
  logic          frame_tick;
  logic          reseed_n;
  logic          level_ok;
  logic [1:0]    retries;
  logic          busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: mode 0 idle, 1 seeding/settling/auditing, 2 running.
  int m_mode    = 0;
  int m_elapsed = 0;
  int m_attempt = 0;
  int m_active  = 0;
  int m_sweep   = -1;
  bit m_bad     = 1'b0;
  bit m_ok      = 1'b0;

  int tbl_spd [4][4] = '{'{-256, -7, 3, -2}, '{5, 5, -5, -5}, '{6, -6, 6, -6}, '{-6, -6, 3, 2}};
  int tbl_ok  [4]    = '{0, 1, 1, 0};
  int tbl_ret [4]    = '{3, 0, 0, 3};

  lane_scheduler #(
    .NUM_LANES(NL), .TICK_DIV(TD), .SEED_CYCLES(SC),
    .SETTLE_CYCLES(STC), .FAST_THRESH(FT), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .level_start(level_start),
    .freeze(freeze), .lane_speed(lane_speed), .step_en(step_en),
    .frame_tick(frame_tick), .reseed_n(reseed_n), .level_ok(level_ok),
    .retries(retries), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic ls, input logic frz);
    @(negedge clk);
    enable      = en;
    level_start = ls;
    freeze      = frz;
  endtask

  task automatic set_speeds(input int s0, input int s1, input int s2, input int s3);
    lane_speed = {9'(s3), 9'(s2), 9'(s1), 9'(s0)};
  endtask

  function automatic int lane_val(input int i);
    return int'($signed(lane_speed[9*i +: 9]));
  endfunction

  function automatic bit lanes_unwinnable(input int a, input int b);
    int ma;
    int mb;
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    return (ma >= FT && mb >= FT && ((a < 0) == (b < 0))) || a == 0 || b == 0;
  endfunction

  function automatic int rand_speed();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0) return -256;
    if (r == 1) return 255;
    if (r == 2) return 0;
    return int'($urandom_range(0, 20)) - 10;
  endfunction

  task automatic pulse_level_start();
    applyStimulus(1'b1, 1'b1, freeze);
    applyStimulus(1'b1, 1'b0, freeze);
  endtask

  task automatic wait_not_busy();
    int k;
    k = 0;
    while (busy && k < 200) begin
      applyStimulus(1'b1, 1'b0, freeze);
      k++;
    end
    if (busy) checkOutput("busy timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_tick(input logic frz);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, 1'b0, frz);
      if (frame_tick) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("tick seen", 32'(found), 32'd1);
  endtask

  // Advance the reference timeline at each rising edge using the inputs held there.
  always @(posedge clk) begin : model
    bit cur_tick;
    int idx;
    cur_tick = (m_mode != 0) && (m_active % TD == TD - 1);
    if (!rst || !enable) begin
      m_mode = 0; m_elapsed = 0; m_attempt = 0; m_active = 0;
      m_sweep = -1; m_bad = 1'b0; m_ok = 1'b0;
    end else begin
      if (m_sweep >= 0) m_sweep = (m_sweep == NL - 1) ? -1 : m_sweep + 1;
      else if (m_mode == 2 && cur_tick && !freeze) m_sweep = 0;
      if (m_mode != 0) m_active++;
      if (level_start) begin
        m_mode = 1; m_elapsed = 0; m_attempt = 0; m_ok = 1'b0; m_bad = 1'b0; m_sweep = -1;
      end else if (m_mode == 1) begin
        if (m_elapsed >= SC + STC) begin
          idx = m_elapsed - (SC + STC);
          if (lanes_unwinnable(lane_val(idx), lane_val(idx + 1))) m_bad = 1'b1;
          if (idx == NL - 2) begin
            if (!m_bad) begin
              m_mode = 2; m_ok = 1'b1;
            end else if (m_attempt == MR) begin
              m_mode = 2; m_ok = 1'b0;
            end else begin
              m_attempt++; m_elapsed = 0; m_bad = 1'b0;
            end
          end else begin
            m_elapsed++;
          end
        end else begin
          m_elapsed++;
        end
      end
    end
  end

  always @(posedge clk) begin : compare
    #1;
    checkOutput("step_en", 32'(step_en), (m_sweep >= 0) ? (32'd1 << m_sweep) : 32'd0);
    checkOutput("frame_tick", 32'(frame_tick), 32'((m_mode != 0) && (m_active % TD == TD - 1)));
    checkOutput("reseed_n", 32'(reseed_n), 32'(!(m_mode == 1 && m_elapsed < SC)));
    checkOutput("busy", 32'(busy), 32'(m_mode == 1));
    checkOutput("level_ok", 32'(level_ok), 32'(m_ok));
    checkOutput("retries", 32'(retries), 32'(m_attempt));
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int busy_cycles;
    int falls;
    int rises;
    int nonzero;
    int ticks;
    int en_hold;
    bit prev;
    logic frz;

    rst = 1'b0; enable = 1'b0; level_start = 1'b0; freeze = 1'b0;
    set_speeds(3, -7, 7, -2);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset step_en", 32'(step_en), 32'd0);
    checkOutput("reset reseed_n", 32'(reseed_n), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset retries", 32'(retries), 32'd0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);

    // Passing level: reseed low 2 cycles, 9 busy cycles, then RUN with level_ok.
    pulse_level_start();
    checkOutput("seed start reseed_n", 32'(reseed_n), 32'd0);
    checkOutput("seed start busy", 32'(busy), 32'd1);
    busy_cycles = 1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("seed hold reseed_n", 32'(reseed_n), 32'd0);
    busy_cycles++;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("seed release reseed_n", 32'(reseed_n), 32'd1);
    busy_cycles++;
    for (int k = 0; k < 50 && busy; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (busy) busy_cycles++;
    end
    checkOutput("busy length", 32'(busy_cycles), 32'd9);
    checkOutput("pass level_ok", 32'(level_ok), 32'd1);
    checkOutput("pass retries", 32'(retries), 32'd0);

    // Sweep after a tick, then a frozen tick that steps nothing.
    wait_tick(1'b0);
    for (int i = 0; i < NL; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("sweep lane", 32'(step_en), 32'd1 << i);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sweep done", 32'(step_en), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    wait_tick(1'b1);
    nonzero = 0;
    repeat (5) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      if (step_en != '0) nonzero++;
    end
    checkOutput("frozen no step", 32'(nonzero), 32'd0);

    // Abort mid-sweep.
    wait_tick(1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("abort lane0", 32'(step_en), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("abort lane1", 32'(step_en), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("abort step_en", 32'(step_en), 32'd0);
    checkOutput("abort reseed_n", 32'(reseed_n), 32'd0);
    checkOutput("abort level_ok", 32'(level_ok), 32'd0);
    wait_not_busy();

    // Unwinnable held: four reseeds, level played as is.
    set_speeds(7, 8, -2, 3);
    pulse_level_start();
    falls = 0;
    prev = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (prev && !reseed_n) falls++;
      prev = reseed_n;
      if (!busy) break;
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("exhaust reseeds", 32'(falls), 32'd4);
    checkOutput("exhaust retries", 32'(retries), 32'd3);
    checkOutput("exhaust level_ok", 32'(level_ok), 32'd0);

    // Zero speed fixed during the second settle: one retry.
    set_speeds(3, -7, 0, -2);
    pulse_level_start();
    rises = 0;
    prev = reseed_n;
    for (int k = 0; k < 200 && busy; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (!prev && reseed_n) begin
        rises++;
        if (rises == 2) lane_speed[18 +: 9] = 9'(2);
      end
      prev = reseed_n;
    end
    checkOutput("zero retries", 32'(retries), 32'd1);
    checkOutput("zero level_ok", 32'(level_ok), 32'd1);

    // Threshold and -256 boundaries.
    for (int t = 0; t < 4; t++) begin
      set_speeds(tbl_spd[t][0], tbl_spd[t][1], tbl_spd[t][2], tbl_spd[t][3]);
      pulse_level_start();
      wait_not_busy();
      checkOutput("table level_ok", 32'(level_ok), 32'(tbl_ok[t]));
      checkOutput("table retries", 32'(retries), 32'(tbl_ret[t]));
    end

    // Async reset during SEED.
    set_speeds(3, -7, 7, -2);
    pulse_level_start();
    applyStimulus(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("async reseed_n", 32'(reseed_n), 32'd1);
    checkOutput("async busy", 32'(busy), 32'd0);
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0);
    rst = 1'b1;

    // enable low in RUN.
    pulse_level_start();
    wait_not_busy();
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("disable busy", 32'(busy), 32'd0);
    checkOutput("disable step_en", 32'(step_en), 32'd0);
    ticks = 0;
    repeat (40) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (frame_tick) ticks++;
    end
    checkOutput("disable ticks", 32'(ticks), 32'd0);

    // Random traffic against the model.
    en_hold = 0;
    frz = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) set_speeds(rand_speed(), rand_speed(), rand_speed(), rand_speed());
      else if ($urandom_range(0, 9) == 0) lane_speed[9*$urandom_range(0, NL-1) +: 9] = 9'(rand_speed());
      if ($urandom_range(0, 39) == 0) frz = ~frz;
      if (en_hold > 0) en_hold--;
      else if ($urandom_range(0, 499) == 0) en_hold = int'($urandom_range(1, 5));
      applyStimulus(en_hold == 0, $urandom_range(0, 59) == 0, frz);
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lane_scheduler.md
# lane_scheduler

Central sequencer for the per-lane car/log movers. Generates the shared movement tick, issues one-cycle step enables to each lane in a fixed sweep, and runs a reseed/audit loop at level start: it pulses the movers' reseed, reads back every lane's signed speed, and re-rolls the level when adjacent lanes are unwinnable. It sits between the top-level game FSM and the array of lane mover instances.

## Interface
- NUM_LANES, 8, number of mover instances (2..16)
- TICK_DIV, 2000000, clk cycles per movement tick; must exceed NUM_LANES+1
- SEED_CYCLES, 4, cycles reseed_n is held low
- SETTLE_CYCLES, 8, cycles waited after reseed release before audit
- FAST_THRESH, 6, |speed| at or above this counts as fast
- MAX_RETRY, 3, reseed attempts after the first before giving up

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  game running; low forces IDLE
- level_start  in  1  one-cycle pulse: begin new level (seed + audit)
- freeze  in  1  high suppresses step sweeps (pause/death)
- lane_speed  in  9*NUM_LANES  signed two's-complement speed per lane, lane i at [9i+8:9i]
- step_en  out  NUM_LANES  one-hot one-cycle move enable per lane
- frame_tick  out  1  one-cycle pulse every TICK_DIV cycles
- reseed_n  out  1  active-low reseed to all movers
- level_ok  out  1  last audit passed
- retries  out  2  reseed attempts consumed in current level
- busy  out  1  high in SEED, SETTLE, AUDIT

## Operation
- States: IDLE, SEED, SETTLE, AUDIT, RUN.
- IDLE: all outputs at reset values. level_start with enable high -> SEED, retries cleared.
- SEED: reseed_n low exactly SEED_CYCLES cycles -> SETTLE.
- SETTLE: wait SETTLE_CYCLES -> AUDIT, lane index 0.
- AUDIT: one lane pair per cycle, i = 0..NUM_LANES-2; pair fails if both |speed| >= FAST_THRESH and signs equal. Any lane with speed 0 also fails. Takes NUM_LANES-1 cycles.
  - Pass -> RUN, level_ok=1.
  - Fail and retries < MAX_RETRY -> retries+1, SEED.
  - Fail and retries == MAX_RETRY -> RUN, level_ok=0 (level played as is).
- RUN: on each frame_tick with freeze low, sweep: step_en[0] next cycle, step_en[1] cycle after, ..., one lane per cycle, then idle until next tick. freeze rising mid-sweep: finish current sweep; ticks arriving while freeze high start no sweep.
- Magnitude: |s| = -s for s negative, computed in 9 bits; -256 treated as fast.
- level_start in any non-IDLE state: abort, clear retries and level_ok, -> SEED next cycle; an in-progress sweep is cut off.
- enable low in any state: -> IDLE next cycle, step_en cleared, reseed_n 1.

## Timing
- Reset values: step_en=0, frame_tick=0, reseed_n=1, level_ok=0, retries=0, busy=0, state IDLE, divider 0.
- Divider counts in every state except IDLE; frame_tick high on the cycle divider == TICK_DIV-1, divider wraps to 0 same edge.
- level_start at edge N: reseed_n low cycles N+1..N+SEED_CYCLES; busy high from N+1.
- Audit result registered; RUN entered SEED_CYCLES+SETTLE_CYCLES+NUM_LANES-1 cycles after SEED entry (pass case); busy drops on RUN entry.
- frame_tick at cycle T (RUN, freeze low): step_en[i] high at T+1+i only.
- All outputs registered; no combinational path input -> output.
- Async reset mid-sweep or mid-seed: immediate return to reset values.

## Test plan
- NUM_LANES=4, TICK_DIV=16, SEED_CYCLES=2, SETTLE_CYCLES=4; speeds {+3,-7,+7,-2}, level_start -> reseed_n low 2 cycles, RUN after 9 cycles, level_ok=1, retries=0.
- Speeds {+7,+8,-2,+3} held -> three reseeds after the first, retries=3, RUN with level_ok=0.
- Speed lane2 = 0 once, then fixed to +2 during second SETTLE -> one retry, level_ok=1, retries=1.
- In RUN, frame_tick at T -> step_en 0001,0010,0100,1000 at T+1..T+4; freeze high before next tick -> no step_en for that tick, frame_tick still pulses.
- level_start mid-sweep (after step_en[1]) -> step_en stops, reseed_n low next cycle, level_ok=0.
- rst low during SEED -> reseed_n=1, busy=0 immediately; enable low in RUN -> IDLE next cycle, frame_tick ceases.
